// File: rtl/axis_hdr_pkg.sv
// axis_hdr_pkg: FSM state encoding, byte-width constants and keep-mask helpers
// shared by the header inserter and its byte-merge datapath.
package axis_hdr_pkg;

  localparam int BYTE_W    = 8;
  // Helper functions work on masks this wide; covers data widths up to 512 bits.
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } hdr_state_e;

  // Number of set bits in a keep mask (header or payload byte count).
  function automatic logic [7:0] keep_popcount(input logic [MAX_BYTES-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      cnt = cnt + {7'd0, keep[i]};
    end
    return cnt;
  endfunction

  // MSB-aligned keep mask with 'count' ones inside an 'nbytes'-wide beat.
  function automatic logic [MAX_BYTES-1:0] keep_from_count(input int count, input int nbytes);
    logic [MAX_BYTES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < nbytes) && (i >= nbytes - count)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_hdr_insert_gen_merge.sv
// axis_byte_merge: combinational byte re-packer. Places the N residual bytes in
// the MSBs followed by the first B-N input bytes, and keeps the last N input
// bytes as the next residual. Residual bytes are held LSB-aligned.
module axis_byte_merge
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int CNT_W   = 3
) (
  input  logic [DATA_WD-1:0] res_i,
  input  logic [DATA_WD-1:0] data_i,
  input  logic [CNT_W-1:0]   n_i,
  output logic [DATA_WD-1:0] merged_o,
  output logic [DATA_WD-1:0] res_next_o
);

  logic [CNT_W+2:0] shift_bits;

  // Whole-byte barrel shift of {residual, input}; the low beat is the output.
  always_comb begin
    shift_bits = (CNT_W+3)'(n_i) * (CNT_W+3)'(BYTE_W);
    merged_o   = DATA_WD'({res_i, data_i} >> shift_bits);
    res_next_o = data_i & ~({DATA_WD{1'b1}} << shift_bits);
  end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// axis_hdr_insert_gen: AXI-Stream header inserter. Prepends the valid header
// bytes of one header beat to each packet and re-packs the payload beats.
// Optional macro AXIS_HDR_BYPASS_EN adds a bypass_insert input that forces an
// empty header for the packet it is sampled with.
module axis_hdr_insert_gen
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  input  logic                    valid_insert,
  output logic                    ready_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
`ifdef AXIS_HDR_BYPASS_EN
  input  logic                    bypass_insert,
`endif
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  output logic [BYTE_CNT_WD:0]    hdr_bytes
);

  localparam int CNT_W = BYTE_CNT_WD + 1;

  hdr_state_e                state_q, state_d;
  logic [CNT_W-1:0]          n_q, n_d;
  logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
  logic [DATA_WD-1:0]        res_q, res_d;
  logic                      valid_q, valid_d;
  logic [DATA_WD-1:0]        data_q, data_d;
  logic [DATA_BYTE_WD-1:0]   keep_q, keep_d;
  logic                      last_q, last_d;
  logic                      rdy_ins_q, rdy_ins_d;

  logic                      out_free;
  logic                      ins_fire;
  logic                      in_fire;
  logic [CNT_W-1:0]          hdr_cnt;
  logic [CNT_W-1:0]          hdr_n;
  logic [CNT_W-1:0]          k_cnt;
  logic [CNT_W:0]            n_sum;
  logic                      fits;
  logic [CNT_W-1:0]          free_bytes;
  logic [DATA_WD-1:0]        flush_data;
  logic [DATA_WD-1:0]        merged;
  logic [DATA_WD-1:0]        res_next;

  axis_byte_merge #(
    .DATA_WD (DATA_WD),
    .CNT_W   (CNT_W)
  ) u_merge (
    .res_i      (res_q),
    .data_i     (data_in),
    .n_i        (n_q),
    .merged_o   (merged),
    .res_next_o (res_next)
  );

  // Handshake qualifiers, byte counts and the flush beat built from the residual.
  always_comb begin
    out_free   = !valid_q || ready_out;
    ready_in   = (state_q == ST_STREAM) && out_free;
    ins_fire   = valid_insert && rdy_ins_q;
    in_fire    = valid_in && ready_in;
    hdr_cnt    = CNT_W'(keep_popcount(MAX_BYTES'(keep_insert)));
`ifdef AXIS_HDR_BYPASS_EN
    hdr_n      = bypass_insert ? '0 : hdr_cnt;
`else
    hdr_n      = hdr_cnt;
`endif
    k_cnt      = CNT_W'(keep_popcount(MAX_BYTES'(keep_in)));
    n_sum      = (CNT_W+1)'(n_q) + (CNT_W+1)'(k_cnt);
    fits       = n_sum <= (CNT_W+1)'(DATA_BYTE_WD);
    free_bytes = CNT_W'(DATA_BYTE_WD) - n_q;
    flush_data = res_q << ((CNT_W+3)'(free_bytes) * (CNT_W+3)'(BYTE_W));
  end

  // Packet FSM: latch header, stream re-packed beats, flush leftover, drain last.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    flush_cnt_d = flush_cnt_q;
    res_d       = res_q;
    valid_d     = valid_q;
    data_d      = data_q;
    keep_d      = keep_q;
    last_d      = last_q;
    if (ready_out) begin
      valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (ins_fire) begin
          n_d     = hdr_n;
          res_d   = data_insert & ~({DATA_WD{1'b1}} << ((CNT_W+3)'(hdr_n) * (CNT_W+3)'(BYTE_W)));
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (in_fire) begin
          valid_d = 1'b1;
          data_d  = merged;
          res_d   = res_next;
          keep_d  = '1;
          last_d  = 1'b0;
          if (last_in) begin
            if (fits) begin
              keep_d  = DATA_BYTE_WD'(keep_from_count(int'(n_sum), DATA_BYTE_WD));
              last_d  = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              flush_cnt_d = CNT_W'(n_sum - (CNT_W+1)'(DATA_BYTE_WD));
              state_d     = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d  = flush_data;
          keep_d  = DATA_BYTE_WD'(keep_from_count(int'(flush_cnt_q), DATA_BYTE_WD));
          last_d  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_free) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_ins_d = (state_d == ST_IDLE);
  end

  // State, residual and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      flush_cnt_q <= '0;
      res_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      rdy_ins_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      flush_cnt_q <= flush_cnt_d;
      res_q       <= res_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      rdy_ins_q   <= rdy_ins_d;
    end
  end

  assign valid_out    = valid_q;
  assign data_out     = data_q;
  assign keep_out     = keep_q;
  assign last_out     = last_q;
  assign ready_insert = rdy_ins_q;
  assign hdr_bytes    = n_q;

endmodule

// File: doc/axis_hdr_insert_gen.md
# axis_hdr_insert_gen

Parametrised AXI-Stream header inserter, the next generation of the single-width header insertion block. Per packet it takes one header beat with byte-contiguous `keep_insert`, prepends the valid header bytes to the payload, and re-packs all following beats across byte boundaries. Full `ready_out` backpressure is supported, and packets may follow each other with at most one bubble cycle. The block sits between a packet source and any AXI-Stream sink on the datapath.

## Interface
- `DATA_WD`, 32: data width in bits; a multiple of 8, at least 16.
- `DATA_BYTE_WD`, `DATA_WD/8`: bytes per beat (B).
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`: width of the byte-count field.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` / `ready_in` in/out 1: payload handshake.
- `data_in` in DATA_WD: payload; byte 0 is in the MSBs and goes first on the wire.
- `keep_in` in DATA_BYTE_WD: all ones except on the last beat, where it is MSB-aligned and contiguous.
- `last_in` in 1: last payload beat.
- `valid_insert` / `ready_insert` in/out 1: header handshake.
- `data_insert` in DATA_WD: header beat.
- `keep_insert` in DATA_BYTE_WD: LSB-aligned, contiguous ones.
- `valid_out` / `ready_out` out/in 1: output handshake.
- `data_out` out DATA_WD: output data.
- `keep_out` out DATA_BYTE_WD: output byte enables.
- `last_out` out 1: last output beat.
- `hdr_bytes` out BYTE_CNT_WD+1: N, the number of header bytes latched for the current packet.

## Operation
- N = popcount(`keep_insert`), range 0..B. A `keep_insert` that is non-contiguous gives undefined data, but the control path must still follow N.
- FSM states:
  - IDLE: `ready_insert`=1 and `ready_in`=0. A header handshake latches N and the N header bytes into the residual register, then goes to STREAM. If N=0 it goes to STREAM with an empty residual, and the packet passes through unchanged.
  - STREAM: `ready_in` = !`valid_out` || `ready_out`. Each accepted beat produces one output beat: the N residual bytes in the MSBs, followed by the first B−N bytes of the input. The last N input bytes become the new residual.
  - STREAM, on the last input beat with K valid bytes:
    - If N+K ≤ B: the output beat has `keep_out` equal to N+K MSB ones and `last_out`=1, and the FSM goes to DRAIN.
    - Otherwise the output beat is full with `last_out`=0, and the FSM goes to FLUSH.
  - FLUSH: `ready_in`=0. When the output register is free, emit the residual with `keep_out` equal to N+K−B MSB ones and `last_out`=1, then go to DRAIN.
  - DRAIN: wait until the beat with `last_out` is accepted, then go to IDLE.
- When N=B the header is a full beat, and data passes through shifted by exactly one beat. The FSM goes to FLUSH on every last beat.
- The output is registered: `data_out`, `keep_out`, `last_out` and `valid_out` come from the output register. While `valid_out`=1 and `ready_out`=0, they must stay stable.
- A header offered during STREAM, FLUSH or DRAIN waits (`ready_insert`=0). Payload offered in IDLE waits (`ready_in`=0).

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `keep_out`=0, `last_out`=0, `ready_in`=0, `ready_insert`=0 (while reset is asserted), `hdr_bytes`=0, FSM=IDLE, residual register=0.
- `ready_insert` rises in the first cycle after reset is released.
- Latency is 1 cycle from an input handshake to `valid_out`.
- With `ready_out` held high, throughput is 1 beat per cycle, plus one FLUSH cycle when N+K > B.
- Between packets: the header for packet n+1 is accepted in the cycle after the last beat of packet n is accepted at the output. This is a gap of at most one idle cycle.
- Reset asserted mid-packet clears everything asynchronously. There is no partial output after release, and the next accepted beat must be a header.

## Configuration
- Macro `AXIS_HDR_BYPASS_EN`.
  - Defined: adds input `bypass_insert` (1 bit), sampled together with the header handshake. When it is 1, N is forced to 0, the header bytes are discarded, and `hdr_bytes` reads 0.
  - Undefined: the port does not exist, and N always comes from `keep_insert`.

## Structure
- Package `axis_hdr_pkg` holds:
  - the FSM state enum (IDLE, STREAM, FLUSH, DRAIN);
  - function `keep_popcount`;
  - function `keep_from_count` (MSB-aligned mask from a count);
  - byte-width localparams.
- Sub-module `axis_byte_merge`: combinational. Inputs are the residual, the input beat and N. Outputs are the merged beat and the next residual. It uses a barrel shift in whole bytes.
- The top level holds the FSM, the residual register and the output register.

## Test plan
All scenarios use B=4.
1. Header 0xAABBCCDD with `keep_insert`=0011; 3 payload beats 0x11223344, 0x55667788, 0x99AABBCC, last `keep_in`=1111.
   → Output 0xCCDD1122, 0x33445566, 0x778899AA, then 0xBBCC0000 with `keep_out`=1100 and `last_out`=1, which exercises FLUSH.
2. Header `keep_insert`=0001; last `keep_in`=1000 (N+K=2).
   → The final beat has `keep_out`=1100, `last_out`=1, and there is no FLUSH cycle.
3. Scenario 1 with `ready_out` toggled randomly at 50%.
   → Identical beat sequence, and outputs stay stable while stalled.
4. `keep_insert`=1111, 2 payload beats.
   → Output is the header beat followed by both payload beats unchanged; `keep_out` on the last beat equals `keep_in`.
5. Reset asserted during the second payload beat, then a fresh packet.
   → Outputs are 0 immediately; the new packet's output carries only the new header.
6. With `AXIS_HDR_BYPASS_EN`, `bypass_insert`=1.
   → `data_out` equals `data_in` beat for beat, and `hdr_bytes`=0.
